// File: rtl/dot_operand_feeder.sv
// Operand feeder for the dot-product Multiplier: packs (A,B) pairs into memA/memB lanes
// and registers memR as a valid/ready result. Define DOT_FEEDER_OVERLAP_EN to fill the next vector during OUT.
module dot_operand_feeder #(
    parameter int N_COLS     = 4,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_a,
    input  logic [DATA_WIDTH-1:0] in_b,
    input  logic                  in_last,
    output logic [DATA_WIDTH-1:0] memA [N_COLS],
    output logic [DATA_WIDTH-1:0] memB [N_COLS],
    input  logic [DATA_WIDTH-1:0] mul_r,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic                  res_short
);

    localparam int              IDX_W    = $clog2(N_COLS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_COLS - 1);

    typedef enum logic [1:0] {FILL, CAPTURE, OUT} state_t;

    state_t                  state_q;
    logic [IDX_W-1:0]        idx_q;
    logic [IDX_W-1:0]        idx_d;
    logic                    short_q;
    logic                    in_ready_q;
    logic                    res_valid_q;
    logic                    res_short_q;
    logic [DATA_WIDTH-1:0]   res_data_q;
    logic [DATA_WIDTH-1:0]   mem_a_q [N_COLS];
    logic [DATA_WIDTH-1:0]   mem_b_q [N_COLS];
`ifdef DOT_FEEDER_OVERLAP_EN
    logic                    full_q;
`endif

    logic accept;
    logic pair_done;
    logic consume;

    always_comb begin
        accept    = in_valid && in_ready_q;
        pair_done = accept && (in_last || (idx_q == LAST_IDX));
        consume   = res_valid_q && res_ready;
        idx_d     = idx_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= FILL;
            idx_q       <= '0;
            short_q     <= 1'b0;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            res_short_q <= 1'b0;
            res_data_q  <= '0;
`ifdef DOT_FEEDER_OVERLAP_EN
            full_q      <= 1'b0;
`endif
            for (int unsigned i = 0; i < N_COLS; i++) begin
                mem_a_q[i] <= '0;
                mem_b_q[i] <= '0;
            end
        end else begin
            case (state_q)
                FILL: begin
                    in_ready_q <= 1'b1;
                    if (accept) begin
                        mem_a_q[idx_q] <= in_a;
                        mem_b_q[idx_q] <= in_b;
                        idx_q          <= idx_d;
                    end
                    if (pair_done) begin
                        short_q    <= (idx_q != LAST_IDX);
                        in_ready_q <= 1'b0;
                        state_q    <= CAPTURE;
                    end
                end
                CAPTURE: begin
                    // memA/memB are stable here, so mul_r reflects the complete vector
                    res_data_q  <= mul_r;
                    res_short_q <= short_q;
                    res_valid_q <= 1'b1;
                    idx_q       <= '0;
                    for (int unsigned i = 0; i < N_COLS; i++) begin
                        mem_a_q[i] <= '0;
                        mem_b_q[i] <= '0;
                    end
`ifdef DOT_FEEDER_OVERLAP_EN
                    full_q      <= 1'b0;
                    in_ready_q  <= 1'b1;
`else
                    in_ready_q  <= 1'b0;
`endif
                    state_q     <= OUT;
                end
                OUT: begin
`ifdef DOT_FEEDER_OVERLAP_EN
                    if (accept) begin
                        mem_a_q[idx_q] <= in_a;
                        mem_b_q[idx_q] <= in_b;
                        idx_q          <= idx_d;
                    end
                    if (pair_done) begin
                        full_q     <= 1'b1;
                        short_q    <= (idx_q != LAST_IDX);
                        in_ready_q <= 1'b0;
                    end
                    // A vector completing in the same cycle the result leaves goes straight to CAPTURE
                    if (consume) begin
                        res_valid_q <= 1'b0;
                        if (full_q || pair_done) begin
                            state_q    <= CAPTURE;
                            in_ready_q <= 1'b0;
                        end else begin
                            state_q    <= FILL;
                            in_ready_q <= 1'b1;
                        end
                    end
`else
                    if (consume) begin
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= FILL;
                    end
`endif
                end
                default: begin
                    state_q    <= FILL;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign res_short = res_short_q;
    assign memA      = mem_a_q;
    assign memB      = mem_b_q;

endmodule

// File: tb/tb_dot_operand_feeder.sv
// Self-checking bench for dot_operand_feeder: directed cases plus randomized vectors against a
// pair-level dot-product scoreboard. Also builds with DOT_FEEDER_OVERLAP_EN defined.
module tb_dot_operand_feeder;

    localparam int N = 4;
    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] in_a;
    logic [W-1:0] in_b;
    logic         in_last;
    logic [W-1:0] memA [N];
    logic [W-1:0] memB [N];
    logic [W-1:0] mul_r;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_data;
    logic         res_short;

    dot_operand_feeder #(.N_COLS(N), .DATA_WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_a     (in_a),
        .in_b     (in_b),
        .in_last  (in_last),
        .memA     (memA),
        .memB     (memB),
        .mul_r    (mul_r),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_short(res_short)
    );

    always #5 clk = ~clk;

    // Multiplier stand-in: combinational modulo-2^W dot product of the lanes
    always_comb begin
        mul_r = '0;
        for (int i = 0; i < N; i++) mul_r = mul_r + memA[i] * memB[i];
    end

    int n_pass = 0;
    int n_chk  = 0;
    int n_results = 0;
    bit rr_random = 1'b0;

    typedef struct {
        logic [W-1:0] d;
        logic         s;
    } exp_t;
    exp_t exp_q[$];

    logic [W-1:0] va [N];
    logic [W-1:0] vb [N];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input int n, input bit last_at_end, input bit throttle);
        bit fired;
        int t;
        for (int k = 0; k < n; k++) begin
            while (throttle && $urandom_range(0, 2) == 0) begin
                in_valid = 1'b0;
                in_a     = $urandom;
                in_b     = $urandom;
                in_last  = 1'($urandom);
                cyc();
            end
            in_valid = 1'b1;
            in_a     = va[k];
            in_b     = vb[k];
            in_last  = last_at_end && (k == n - 1);
            fired = 1'b0;
            t = 0;
            while (!fired && t < 200) begin
                @(negedge clk);
                fired = in_valid && in_ready;
                cyc();
                t++;
            end
            chk("accept_in_time", fired, 1);
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Scoreboard: accumulates accepted pairs into expected results, checks every consumed result
    initial begin
        logic [W-1:0] acc_m;
        int           cnt_m;
        bit           prev_hold;
        logic [W-1:0] prev_data;
        logic         prev_short;
        exp_t         e;
        acc_m = '0;
        cnt_m = 0;
        prev_hold = 1'b0;
        prev_data = '0;
        prev_short = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                exp_q.delete();
                acc_m = '0;
                cnt_m = 0;
                prev_hold = 1'b0;
                continue;
            end
            if (prev_hold) begin
                chk("hold_valid", res_valid, 1);
                chk("hold_data", res_data, prev_data);
                chk("hold_short", res_short, prev_short);
            end
`ifndef DOT_FEEDER_OVERLAP_EN
            if (res_valid) chk("no_ready_while_result", in_ready, 0);
`endif
            if (in_valid && in_ready) begin
                acc_m = acc_m + in_a * in_b;
                cnt_m++;
                if (cnt_m == N || in_last) begin
                    e.d = acc_m;
                    e.s = (cnt_m < N);
                    exp_q.push_back(e);
                    acc_m = '0;
                    cnt_m = 0;
                end
            end
            if (res_valid && res_ready) begin
                n_results++;
                chk("result_pending", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    chk("sb_data", res_data, e.d);
                    chk("sb_short", res_short, e.s);
                end
            end
            prev_hold  = res_valid && !res_ready;
            prev_data  = res_data;
            prev_short = res_short;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rr_random) res_ready = 1'($urandom);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int base;
        int len;
        bit lae;
        rst = 1'b1; in_valid = 1'b0; in_a = '0; in_b = '0; in_last = 1'b0; res_ready = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_res_valid", res_valid, 0);
        chk("rst_res_data", res_data, 0);
        chk("rst_res_short", res_short, 0);
        for (int i = 0; i < N; i++) begin
            chk("rst_memA", memA[i], 0);
            chk("rst_memB", memB[i], 0);
        end
        cyc();
        rst = 1'b0;
        cyc();
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1);
        cyc();

        // basic 4-element vector and its timing
        res_ready = 1'b1;
        for (int i = 0; i < N; i++) begin va[i] = W'(i + 1); vb[i] = W'(i + 5); end
        send_vec(4, 1'b0, 1'b0);
        @(negedge clk);
        chk("t1_capture_valid", res_valid, 0);
        chk("t1_capture_ready", in_ready, 0);
        chk("t1_memA2", memA[2], 3);
        chk("t1_memB3", memB[3], 8);
        cyc();
        @(negedge clk);
        chk("t1_valid", res_valid, 1);
        chk("t1_data", res_data, 70);
        chk("t1_short", res_short, 0);
        cyc();
        @(negedge clk);
        chk("t1_valid_one_cycle", res_valid, 0);
        cyc();

        // short vector with in_last on the 2nd pair
        va[0] = 3; vb[0] = 3; va[1] = 2; vb[1] = 5;
        send_vec(2, 1'b1, 1'b0);
        @(negedge clk);
        chk("t2_memA0", memA[0], 3);
        chk("t2_memA2_zero", memA[2], 0);
        chk("t2_memA3_zero", memA[3], 0);
        chk("t2_memB2_zero", memB[2], 0);
        chk("t2_memB3_zero", memB[3], 0);
        cyc();
        @(negedge clk);
        chk("t2_data", res_data, 19);
        chk("t2_short", res_short, 1);
        cyc(); cyc();

        // wrap-around result held while downstream stalls; redundant in_last on the final lane
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin va[i] = 32'hFFFF_FFFF; vb[i] = 2; end
        send_vec(4, 1'b1, 1'b0);
        @(negedge clk);
        cyc();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_valid", res_valid, 1);
            chk("t3_data", res_data, 32'hFFFF_FFF8);
            chk("t3_short", res_short, 0);
`ifndef DOT_FEEDER_OVERLAP_EN
            chk("t3_in_ready", in_ready, 0);
`endif
            cyc();
        end
        res_ready = 1'b1;
        cyc(); cyc();
        @(negedge clk);
        chk("t3_released", res_valid, 0);
        cyc();

        // reset in the middle of a vector discards the partial lanes
        for (int i = 0; i < N; i++) begin va[i] = 9; vb[i] = 9; end
        send_vec(2, 1'b0, 1'b0);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        for (int i = 0; i < N; i++) begin va[i] = 1; vb[i] = 1; end
        send_vec(4, 1'b0, 1'b0);
        @(negedge clk);
        cyc();
        @(negedge clk);
        chk("t4_valid", res_valid, 1);
        chk("t4_data", res_data, 4);
        chk("t4_short", res_short, 0);
        cyc(); cyc();

`ifdef DOT_FEEDER_OVERLAP_EN
        // next vector fills while the previous result waits
        res_ready = 1'b0;
        for (int i = 0; i < N; i++) begin va[i] = W'(i + 1); vb[i] = W'(i + 5); end
        send_vec(4, 1'b0, 1'b0);
        for (int i = 0; i < N; i++) begin va[i] = 2; vb[i] = 3; end
        send_vec(4, 1'b0, 1'b0);
        res_ready = 1'b1;
        @(negedge clk);
        chk("ov_ready_full", in_ready, 0);
        chk("ov_valid1", res_valid, 1);
        chk("ov_data1", res_data, 70);
        cyc();
        res_ready = 1'b0;
        @(negedge clk);
        chk("ov_capture_valid", res_valid, 0);
        chk("ov_memA0", memA[0], 2);
        cyc();
        @(negedge clk);
        chk("ov_valid2", res_valid, 1);
        chk("ov_data2", res_data, 24);
        res_ready = 1'b1;
        cyc(); cyc();
`endif

        // randomized lengths, data and handshake throttling
        base = n_results;
        rr_random = 1'b1;
        for (int v = 0; v < 200; v++) begin
            len = $urandom_range(1, N);
            for (int i = 0; i < N; i++) begin
                va[i] = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
                vb[i] = ($urandom_range(0, 1) == 0) ? W'($urandom_range(0, 255)) : W'($urandom);
            end
            lae = (len < N) || ($urandom_range(0, 1) == 1);
            send_vec(len, lae, 1'b1);
        end
        rr_random = 1'b0;
        res_ready = 1'b1;
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) cyc();
        cyc(); cyc();
        chk("drain_queue_empty", exp_q.size(), 0);
        chk("random_result_count", n_results - base, 200);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
